// File: rtl/rv32_pkg.sv
// Shared constants and types for the multi-cycle RV32I core: opcodes, funct3 codes,
// FSM state encoding and a bit-reversal helper used by the shifter.
package rv32_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Slt  = 3'b010;
  localparam logic [2:0] F3Sltu = 3'b011;
  localparam logic [2:0] F3Xor  = 3'b100;
  localparam logic [2:0] F3Sr   = 3'b101;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3And  = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  typedef enum logic [2:0] {
    StFetchInstr,
    StWaitInstr,
    StFetchRegs,
    StExecute,
    StLoad,
    StWaitData,
    StStore,
    StHalt
  } state_e;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU with branch comparator. Left shifts reuse the right shifter
// by reversing the operand before and the result after.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        alt,
  output logic [31:0] result,
  output logic        taken
);

  logic        is_sll;
  logic [31:0] shift_in;
  logic [32:0] shifted;
  logic [31:0] shr;
  logic [32:0] diff;
  logic [31:0] sum;
  logic        lt;
  logic        ltu;

  always_comb begin
    is_sll   = (funct3 == F3Sll);
    shift_in = is_sll ? rev32(a) : a;
    shifted  = $signed({alt & ~is_sll & shift_in[31], shift_in}) >>> b[4:0];
    shr      = shifted[31:0];
    sum      = a + b;
    diff     = {1'b0, a} - {1'b0, b};
    ltu      = diff[32];
    // Differing signs decide signed order directly; otherwise unsigned order holds.
    lt       = (a[31] != b[31]) ? a[31] : diff[32];
  end

  always_comb begin
    result = sum;
    unique case (funct3)
      F3Add:   result = alt ? diff[31:0] : sum;
      F3Sll:   result = rev32(shr);
      F3Slt:   result = {31'b0, lt};
      F3Sltu:  result = {31'b0, ltu};
      F3Xor:   result = a ^ b;
      F3Sr:    result = shr;
      F3Or:    result = a | b;
      F3And:   result = a & b;
      default: result = sum;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3Beq:   taken = (a == b);
      F3Bne:   taken = (a != b);
      F3Blt:   taken = lt;
      F3Bge:   taken = ~lt;
      F3Bltu:  taken = ltu;
      F3Bgeu:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_core.sv
// Multi-cycle RV32I core with one shared busy-handshaked memory port, byte/halfword
// load/store lanes and a sticky halt on SYSTEM instructions.
module rv32i_mc_core
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rbusy,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_wbusy,
  output logic [31:0]           x10,
  output logic                  halted
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           rs1_q, rs2_q;
  logic [31:0]           x10_q;
  logic [31:0]           regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_op, is_branch, is_store;
  logic [31:0] alu_b, alu_res;
  logic        alu_alt, br_taken;

  logic [31:0]           pc32;
  logic [ADDR_WIDTH-1:0] pc_plus4, next_pc;
  logic [31:0]           ls_addr32;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           exec_data, load_val, lane_shift;
  logic [15:0]           lane_half;
  logic                  exec_wb;
  logic [3:0]            store_mask;

  logic        wb_en;
  logic [31:0] wb_data;
  logic        rstrb_int, data_sel;
  logic [3:0]  wmask_int;

  assign opcode    = instr_q[6:0];
  assign rd        = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign imm_i     = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s     = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                      instr_q[11:8], 1'b0};
  assign imm_u     = {instr_q[31:12], 12'b0};
  assign imm_j     = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                      instr_q[30:21], 1'b0};
  assign is_op     = (opcode == OpReg);
  assign is_branch = (opcode == OpBranch);
  assign is_store  = (opcode == OpStore);
  assign alu_b     = (is_op || is_branch) ? rs2_q : imm_i;
  // Bit 30 is only a sub/sra selector for register ops and right-shift immediates.
  assign alu_alt   = instr_q[30] & (is_op | (funct3 == F3Sr));

  rv32_alu u_alu (
    .a      (rs1_q),
    .b      (alu_b),
    .funct3 (funct3),
    .alt    (alu_alt),
    .result (alu_res),
    .taken  (br_taken)
  );

  assign pc32      = 32'(pc_q);
  assign pc_plus4  = pc_q + ADDR_WIDTH'(4);
  assign ls_addr32 = rs1_q + (is_store ? imm_s : imm_i);
  assign ls_addr   = ADDR_WIDTH'(ls_addr32);

  always_comb begin
    next_pc   = pc_plus4;
    exec_data = alu_res;
    exec_wb   = 1'b0;
    case (opcode)
      OpImm, OpReg: exec_wb = 1'b1;
      OpLui: begin
        exec_wb   = 1'b1;
        exec_data = imm_u;
      end
      OpAuipc: begin
        exec_wb   = 1'b1;
        exec_data = pc32 + imm_u;
      end
      OpJal: begin
        exec_wb   = 1'b1;
        exec_data = 32'(pc_plus4);
        next_pc   = ADDR_WIDTH'(pc32 + imm_j);
      end
      OpJalr: begin
        exec_wb   = 1'b1;
        exec_data = 32'(pc_plus4);
        next_pc   = ADDR_WIDTH'((rs1_q + imm_i) & ~32'd1);
      end
      OpBranch: if (br_taken) next_pc = ADDR_WIDTH'(pc32 + imm_b);
      default: ;
    endcase
  end

  always_comb begin
    lane_shift = mem_rdata >> {ls_addr[1:0], 3'b000};
    lane_half  = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3Lb:    load_val = {{24{lane_shift[7]}}, lane_shift[7:0]};
      F3Lh:    load_val = {{16{lane_half[15]}}, lane_half};
      F3Lw:    load_val = mem_rdata;
      F3Lbu:   load_val = {24'b0, lane_shift[7:0]};
      F3Lhu:   load_val = {16'b0, lane_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      SzByte: begin
        mem_wdata  = {4{rs2_q[7:0]}};
        store_mask = 4'b0001 << ls_addr[1:0];
      end
      SzHalf: begin
        mem_wdata  = {2{rs2_q[15:0]}};
        store_mask = 4'b0011 << {ls_addr[1], 1'b0};
      end
      default: begin
        mem_wdata  = rs2_q;
        store_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    wb_en     = 1'b0;
    wb_data   = exec_data;
    rstrb_int = 1'b0;
    wmask_int = 4'b0000;
    data_sel  = 1'b0;
    unique case (state_q)
      StFetchInstr: begin
        rstrb_int = 1'b1;
        state_d   = StWaitInstr;
      end
      StWaitInstr: begin
        if (!mem_rbusy) begin
          instr_d = mem_rdata;
          state_d = StFetchRegs;
        end
      end
      StFetchRegs: state_d = StExecute;
      StExecute: begin
        pc_d    = next_pc;
        wb_en   = exec_wb;
        state_d = StFetchInstr;
        case (opcode)
          OpLoad:   state_d = StLoad;
          OpStore:  state_d = StStore;
          OpSystem: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
          default: ;
        endcase
      end
      StLoad: begin
        data_sel  = 1'b1;
        rstrb_int = 1'b1;
        state_d   = StWaitData;
      end
      StWaitData: begin
        data_sel = 1'b1;
        if (!mem_rbusy) begin
          wb_en   = 1'b1;
          wb_data = load_val;
          state_d = StFetchInstr;
        end
      end
      StStore: begin
        data_sel  = 1'b1;
        wmask_int = store_mask;
        if (!mem_wbusy) state_d = StFetchInstr;
      end
      StHalt: ;
      default: state_d = StFetchInstr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetchInstr;
      pc_q    <= ADDR_WIDTH'(RESET_ADDR);
      instr_q <= InstrNop;
      rs1_q   <= 32'b0;
      rs2_q   <= 32'b0;
      x10_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if (state_q == StFetchRegs) begin
        rs1_q <= (instr_q[19:15] == 5'd0) ? 32'b0 : regs[instr_q[19:15]];
        rs2_q <= (instr_q[24:20] == 5'd0) ? 32'b0 : regs[instr_q[24:20]];
      end
      if (wb_en && rd == 5'd10) x10_q <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
  end

  // Strobes are gated by rst so an in-flight request drops without waiting for a clock.
  assign mem_addr  = data_sel ? {ls_addr[ADDR_WIDTH-1:2], 2'b00} : {pc_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_rstrb = rstrb_int & ~rst;
  assign mem_wmask = rst ? 4'b0000 : wmask_int;
  assign x10       = x10_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: runs a small program through a busy-capable memory
// model, logs fetches and writes, then checks results against hand-computed values.
module tb_rv32i_mc_core;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rstrb;
  logic [31:0]   mem_rdata;
  logic          mem_rbusy;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_wbusy;
  logic [31:0]   x10;
  logic          halted;

  always #5 clk = ~clk;

  rv32i_mc_core #(
    .ADDR_WIDTH (AW),
    .RESET_ADDR (32'h100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_wbusy (mem_wbusy),
    .x10       (x10),
    .halted    (halted)
  );

  logic [31:0] mem [1024];
  logic [31:0] rd_addr = 32'h0;
  int          rbusy_cnt = 0;
  int          wbusy_cnt = 3;
  logic [31:0] busy_addr = 32'h104;
  logic        wbusy_hold = 1'b0;
  logic        patch_en = 1'b0;
  logic [31:0] cyc = 32'h0;

  logic [31:0] s_cyc [$];
  logic [31:0] s_addr [$];
  logic [31:0] s_x10 [$];
  logic [31:0] w_addr [$];
  logic [31:0] w_data [$];
  logic [31:0] w_mask [$];
  int          sw_cycles = 0;
  logic        sw_unstable = 1'b0;
  logic [31:0] sw_addr0 = 32'h0;
  logic [31:0] sw_data0 = 32'h0;
  int          overlap = 0;
  int          halt_strobes = 0;

  int n_vec = 0;
  int n_miss = 0;

  // While busy, the read bus carries a decoy (addi x10,x0,2047) to expose early latching.
  assign mem_rbusy = (rbusy_cnt != 0);
  assign mem_rdata = mem_rbusy ? 32'h7FF0_0513 :
                     (patch_en && rd_addr[11:2] == 10'd64) ? 32'h0000_2023 :
                     mem[rd_addr[11:2]];
  assign mem_wbusy = (mem_wmask == 4'hF) && (wbusy_cnt != 0 || wbusy_hold);

  initial begin
    foreach (mem[i]) mem[i] = 32'h0000_0013;
    mem[32]   = 32'h8001_FF7F;
    mem[64]   = 32'h0050_0513;  // 100 addi x10,x0,5
    mem[65]   = 32'h00A5_0533;  // 104 add  x10,x10,x10
    mem[66]   = 32'h0800_0093;  // 108 addi x1,x0,0x80
    mem[67]   = 32'h0000_8503;  // 10C lb   x10,0(x1)
    mem[68]   = 32'h0000_C503;  // 110 lbu  x10,0(x1)
    mem[69]   = 32'h0010_8503;  // 114 lb   x10,1(x1)
    mem[70]   = 32'h0020_9503;  // 118 lh   x10,2(x1)
    mem[71]   = 32'h0020_D503;  // 11C lhu  x10,2(x1)
    mem[72]   = 32'h0AB0_0113;  // 120 addi x2,x0,0xAB
    mem[73]   = 32'h0020_81A3;  // 124 sb   x2,3(x1)
    mem[74]   = 32'h0020_9123;  // 128 sh   x2,2(x1)
    mem[75]   = 32'h0020_A023;  // 12C sw   x2,0(x1)
    mem[76]   = 32'h0000_0193;  // 130 addi x3,x0,0
    mem[77]   = 32'h0011_8193;  // 134 addi x3,x3,1
    mem[78]   = 32'h0010_0293;  // 138 addi x5,x0,1
    mem[79]   = 32'hFE51_8CE3;  // 13C beq  x3,x5,-8
    mem[80]   = 32'h0100_0337;  // 140 lui  x6,0x1000
    mem[81]   = 32'hFFC3_0313;  // 144 addi x6,x6,-4
    mem[82]   = 32'h0003_0067;  // 148 jalr x0,0(x6)
    mem[1023] = 32'h0080_006F;  // FFFFFC jal x0,+8 -> 000004
    mem[1]    = 32'h0010_0073;  // 000004 ebreak
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rstrb) begin
      rd_addr   <= 32'(mem_addr);
      rbusy_cnt <= (32'(mem_addr) == busy_addr) ? 3 : 0;
      s_cyc.push_back(cyc);
      s_addr.push_back(32'(mem_addr));
      s_x10.push_back(x10);
    end else if (rbusy_cnt != 0) begin
      rbusy_cnt <= rbusy_cnt - 1;
    end
    if (mem_wmask == 4'hF) begin
      if (wbusy_cnt != 0) wbusy_cnt <= wbusy_cnt - 1;
      if (!wbusy_hold) begin
        sw_cycles <= sw_cycles + 1;
        if (sw_cycles == 0) begin
          sw_addr0 <= 32'(mem_addr);
          sw_data0 <= mem_wdata;
        end else if (32'(mem_addr) != sw_addr0 || mem_wdata != sw_data0) begin
          sw_unstable <= 1'b1;
        end
      end
    end
    if (mem_wmask != 4'h0 && !mem_wbusy) begin
      w_addr.push_back(32'(mem_addr));
      w_data.push_back(mem_wdata);
      w_mask.push_back(32'(mem_wmask));
    end
    if (mem_rstrb && mem_wmask != 4'h0) overlap <= overlap + 1;
    if (halted && (mem_rstrb || mem_wmask != 4'h0)) halt_strobes <= halt_strobes + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    foreach (s_addr[i]) if (s_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [31:0] cyc_at(input logic [31:0] a);
    int i = idx_of(a);
    return (i < 0) ? 32'hxxxx_xxxx : s_cyc[i];
  endfunction

  function automatic logic [31:0] x10_at(input logic [31:0] a);
    int i = idx_of(a);
    return (i < 0) ? 32'hxxxx_xxxx : s_x10[i];
  endfunction

  function automatic logic [31:0] next_after(input logic [31:0] a);
    int i = idx_of(a);
    return (i < 0 || i + 1 >= s_addr.size()) ? 32'hxxxx_xxxx : s_addr[i+1];
  endfunction

  function automatic logic [31:0] wlog(input int i, input int field);
    if (i >= w_addr.size()) return 32'hxxxx_xxxx;
    case (field)
      0:       return w_addr[i];
      1:       return w_data[i];
      default: return w_mask[i];
    endcase
  endfunction

  initial begin
    int n_w;
    repeat (3) @(negedge clk);
    check_eq("rst_rstrb", 32'(mem_rstrb), 32'h0);
    check_eq("rst_wmask", 32'(mem_wmask), 32'h0);
    check_eq("rst_x10", x10, 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    #1;
    check_eq("first_fetch_addr", 32'(mem_addr), 32'h100);
    check_eq("first_fetch_rstrb", 32'(mem_rstrb), 32'h1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check_eq("halt_reached", 32'(halted), 32'h1);
    repeat (10) @(negedge clk);

    check_eq("addi_x10", x10_at(32'h104), 32'd5);
    check_eq("add_x10", x10_at(32'h108), 32'd10);
    check_eq("addi_cycles", cyc_at(32'h104) - cyc_at(32'h100), 32'd4);
    check_eq("add_rbusy_cycles", cyc_at(32'h108) - cyc_at(32'h104), 32'd7);
    check_eq("lb_off0", x10_at(32'h110), 32'h0000_007F);
    check_eq("lbu_off0", x10_at(32'h114), 32'h0000_007F);
    check_eq("lb_off1", x10_at(32'h118), 32'hFFFF_FFFF);
    check_eq("lh_off2", x10_at(32'h11C), 32'hFFFF_8001);
    check_eq("lhu_off2", x10_at(32'h120), 32'h0000_8001);
    check_eq("load_cycles", cyc_at(32'h110) - cyc_at(32'h10C), 32'd6);
    check_eq("sb_cycles", cyc_at(32'h128) - cyc_at(32'h124), 32'd5);
    check_eq("sw_busy_cycles", cyc_at(32'h130) - cyc_at(32'h12C), 32'd8);
    check_eq("n_writes", 32'(w_addr.size()), 32'd3);
    check_eq("sb_addr", wlog(0, 0), 32'h80);
    check_eq("sb_wdata", wlog(0, 1), 32'hABAB_ABAB);
    check_eq("sb_wmask", wlog(0, 2), 32'h8);
    check_eq("sh_wdata", wlog(1, 1), 32'h00AB_00AB);
    check_eq("sh_wmask", wlog(1, 2), 32'hC);
    check_eq("sw_wdata", wlog(2, 1), 32'h0000_00AB);
    check_eq("sw_wmask", wlog(2, 2), 32'hF);
    check_eq("sw_held_cycles", 32'(sw_cycles), 32'd4);
    check_eq("sw_stable", 32'(sw_unstable), 32'h0);
    check_eq("beq_taken_target", next_after(32'h13C), 32'h134);
    check_eq("jalr_target", next_after(32'h148), 32'hFF_FFFC);
    check_eq("jal_wrap_target", next_after(32'hFF_FFFC), 32'h4);
    check_eq("x10_after_jal", x10, 32'h0000_8001);
    check_eq("halt_no_strobes", 32'(halt_strobes), 32'h0);
    check_eq("rd_wr_overlap", 32'(overlap), 32'h0);

    @(negedge clk);
    rst        = 1'b1;
    patch_en   = 1'b1;
    wbusy_hold = 1'b1;
    #1;
    check_eq("rst_clears_halt", 32'(halted), 32'h0);
    check_eq("rst_clears_x10", x10, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_w = w_addr.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wmask != 4'h0) break;
    end
    check_eq("store_pending", 32'(mem_wmask), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_wmask_async", 32'(mem_wmask), 32'h0);
    check_eq("rst_rstrb_low", 32'(mem_rstrb), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("restart_addr", 32'(mem_addr), 32'h100);
    check_eq("restart_rstrb", 32'(mem_rstrb), 32'h1);
    check_eq("no_write_on_rst", 32'(w_addr.size()), 32'(n_w));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_core.md
# rv32i_mc_core

Parametrised multi-cycle RV32I core: successor of the four-state LED demo core, adding full load/store support with byte/halfword lanes, busy-handshaked memory, a configurable reset vector and address width, and a sticky halt. Sits between the SoC memory/IO decoder and the board; one shared memory port serves both instruction fetch and data access.

## Interface
- ADDR_WIDTH, 24: byte-address width of mem_addr and pc (max 32).
- RESET_ADDR, 0: pc value after reset; must be word-aligned.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_addr  out  ADDR_WIDTH  byte address, bits [1:0] always 0.
- mem_rstrb  out  1  read strobe, single-cycle pulse.
- mem_rdata  in  32  read data.
- mem_rbusy  in  1  read not yet complete.
- mem_wdata  out  32  write data, lane-replicated.
- mem_wmask  out  4  byte write enables; nonzero = write request.
- mem_wbusy  in  1  write not yet accepted.
- x10  out  32  mirror of register a0.
- halted  out  1  core stopped on ECALL/EBREAK.

## Operation
- States: FETCH_INSTR, WAIT_INSTR, FETCH_REGS, EXECUTE, LOAD, WAIT_DATA, STORE, HALT.
- FETCH_INSTR: mem_addr=pc, mem_rstrb=1 -> WAIT_INSTR.
- WAIT_INSTR: stay while mem_rbusy; else latch instr=mem_rdata -> FETCH_REGS.
- FETCH_REGS: read rs1, rs2 from 32x32 bank (x0 reads 0) -> EXECUTE.
- EXECUTE: ALU/branch/JAL/JALR/LUI/AUIPC identical to RV32I base semantics; writeback to rd (rd≠0) for all except branch/store/load; pc<=next_pc. Load -> LOAD, store -> STORE, SYSTEM -> HALT (pc unchanged), else -> FETCH_INSTR.
- Load/store address = rs1 + I-imm (load) / S-imm (store), truncated to ADDR_WIDTH; mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
- LOAD: mem_rstrb=1 -> WAIT_DATA. WAIT_DATA: stay while mem_rbusy; else extract lane (byte: addr[1:0], half: addr[1], word: whole), sign-extend for LB/LH, zero-extend for LBU/LHU, write rd -> FETCH_INSTR.
- STORE: mem_wdata = rs2 replicated (byte x4, half x2); mem_wmask = SB 0001<<addr[1:0], SH 0011<<{addr[1],1'b0}, SW 1111. Held until edge with mem_wbusy=0 -> FETCH_INSTR.
- Misaligned accesses are not trapped; offending low bits simply select a lane (halfword at offset 3 uses lanes 3:2).
- HALT: absorbing until reset; halted=1, no strobes.
- x10 updated in the same edge as register 10 write.
- Unknown opcodes execute as NOP (pc+4).

## Timing
- Reset values: pc=RESET_ADDR, state=FETCH_INSTR, instr=NOP, x10=0, halted=0; mem_rstrb=0 and mem_wmask=0 while rst high. Register bank not reset.
- Zero-wait memory: ALU/branch/jump 4 cycles, load 6, store 5; each busy cycle adds one.
- Read rule: mem_rdata sampled in first cycle after strobe with mem_rbusy=0.
- Write rule: request (addr, wdata, wmask) stable until accepted.
- Never read and write in the same cycle; mem_rstrb and mem_wmask mutually exclusive.
- Reset mid-access: immediate abandon; no writeback, wmask drops asynchronously.
- pc arithmetic mod 2^ADDR_WIDTH; jump targets wrap.

## Structure
- Package rv32_pkg: opcode constants, funct3 codes for ALU/branch/load/store, state enum, NOP encoding.
- Sub-module rv32_alu: combinational ALU (add/sub, shifts via single right shifter with bit-reversal, slt/sltu, logic) plus branch-compare output; core keeps decoder, FSM, register bank, load/store lane logic.

## Test plan
- Reset with RESET_ADDR=0x100: first mem_addr=0x100 with mem_rstrb=1 one cycle after rst release; x10=0, halted=0.
- ADDI x10,x0,5 then ADD x10,x10,x10 -> x10=5 then 10; each instruction 4 cycles with zero-wait memory.
- Memory word 0x80 = 0x8001_FF7F; LB/LBU offset 0 -> 0x0000007F; LB offset 1 -> 0xFFFFFFFF; LH offset 2 -> 0xFFFF8001; LHU offset 2 -> 0x00008001.
- SB x=0xAB at 0x83 -> mem_wmask=1000, mem_wdata=0xABABABAB; SH at 0x82 -> 1100; SW -> 1111, held 3 cycles while mem_wbusy=1.
- mem_rbusy high 3 cycles on fetch -> instruction latched only after drop; total ALU instruction 7 cycles.
- BEQ taken to -8, JAL wrap at top of 2^ADDR_WIDTH space, then EBREAK -> halted=1, no further strobes; reset mid-STORE clears wmask immediately and restarts at RESET_ADDR.
